// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: widths, the x0 address
// and the requester indices used by the write-port arbiter.
package regfile_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational grant; the pointer to the
// last granted requester advances only when the grant is actually taken.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       handshake,
  output logic [1:0] grant
);

  logic last_grant_d;
  logic last_grant_q;
  logic [1:0] grant_s;

  // Grant selection; under contention the requester not served last wins
  always_comb begin
    grant_s = 2'b00;
    if (reset) begin
      grant_s = 2'b00;
    end else begin
      case (req)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = (last_grant_q == REQ_LOAD) ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end
  end

  // Pointer update follows whichever side completed its handshake
  always_comb begin
    last_grant_d = last_grant_q;
    if (handshake) begin
      last_grant_d = grant_s[REQ_LOAD];
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Pointer register; reset favours the ALU path on the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_LOAD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths
// and tracks pending destinations so decode can stall on RAW hazards.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]       req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]       req1_data,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_addr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]       wd3
);

  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  logic                  hs0_s;
  logic                  hs1_s;
  logic                  handshake_s;
  logic [REG_ADDR_W-1:0] hs_addr_s;
  logic [XLEN-1:0]       hs_data_s;

  logic                  reg_write_d;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] a3_d;
  logic [REG_ADDR_W-1:0] a3_q;
  logic [XLEN-1:0]       wd3_d;
  logic [XLEN-1:0]       wd3_q;
  logic [NREG-1:0]       busy_d;
  logic [NREG-1:0]       busy_q;

  assign req_s = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_s),
    .handshake (handshake_s),
    .grant     (grant_s)
  );

  assign req0_ready  = grant_s[REQ_ALU];
  assign req1_ready  = grant_s[REQ_LOAD];
  assign hs0_s       = req0_valid & grant_s[REQ_ALU];
  assign hs1_s       = req1_valid & grant_s[REQ_LOAD];
  assign handshake_s = hs0_s | hs1_s;

  // Select the winning request's address and data
  always_comb begin
    hs_addr_s = REG_ZERO;
    hs_data_s = {XLEN{1'b0}};
    if (hs0_s) begin
      hs_addr_s = req0_addr;
      hs_data_s = req0_data;
    end else if (hs1_s) begin
      hs_addr_s = req1_addr;
      hs_data_s = req1_data;
    end else begin
      hs_addr_s = REG_ZERO;
      hs_data_s = {XLEN{1'b0}};
    end
  end

  // Next write-port state; x0 writes are accepted but never reach the port
  always_comb begin
    reg_write_d = handshake_s && (hs_addr_s != REG_ZERO);
    a3_d        = reg_write_d ? hs_addr_s : a3_q;
    wd3_d       = reg_write_d ? hs_data_s : wd3_q;
  end

  // Scoreboard: clear on write, then set, so a newly issued producer wins
  always_comb begin
    busy_d = busy_q;
    busy_d[hs_addr_s] = reg_write_d ? 1'b0 : busy_d[hs_addr_s];
    if (sb_set && (sb_set_addr != REG_ZERO)) begin
      busy_d[sb_set_addr] = 1'b1;
    end else begin
      busy_d[sb_set_addr] = busy_d[sb_set_addr];
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Registered write port and pending-write vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      a3_q        <= REG_ZERO;
      wd3_q       <= {XLEN{1'b0}};
      busy_q      <= {NREG{1'b0}};
    end else begin
      reg_write_q <= reg_write_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      busy_q      <= busy_d;
    end
  end

  // No bypass: a clear landing this edge is only visible next cycle
  assign hazard   = busy_q[rs1] | busy_q[rs2];
  assign RegWrite = reg_write_q;
  assign a3       = a3_q;
  assign wd3      = wd3_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (RegWrite/a3/wd3) between two writeback requesters: requester 0 (ALU/immediate path) and requester 1 (load unit). Uses a round-robin grant with valid/ready handshakes and drives a registered write port into the register file. Keeps a 32-entry pending-write scoreboard that decode uses to stall on read-after-write hazards. It sits between the execute/memory stages and the register file's write side.

## Interface
- XLEN, 32, data width of register and write data
- NREG, 32, number of architectural registers (address width clog2(NREG)=5)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 accepted this cycle
- req0_addr  in  5  destination register
- req0_data  in  XLEN  write data
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1
- sb_set  in  1  decode issued an instruction that will write sb_set_addr
- sb_set_addr  in  5  destination to mark pending
- rs1, rs2  in  5 each  source registers being decoded
- hazard  out  1  rs1 or rs2 is pending (combinational)
- RegWrite  out  1  register-file write enable (registered)
- a3  out  5  write address (registered)
- wd3  out  XLEN  write data (registered)

## Operation
- Grant is combinational. With one valid requester, that requester is granted. With both valid, grant goes to the requester not granted last (last_grant pointer).
- reqN_ready = granted N. A handshake is reqN_valid && reqN_ready.
- At most one handshake per cycle. The losing requester must hold valid, addr and data stable until it is granted.
- last_grant updates only on a handshake.
- On a handshake to addr != 0:
  - next cycle: RegWrite=1, a3=addr, wd3=data;
  - the scoreboard bit for addr is cleared on that same edge.
- On a handshake to addr == 0:
  - the request is accepted (ready=1) and last_grant updates;
  - RegWrite stays 0 next cycle and the scoreboard is untouched.
- No handshake: RegWrite=0 next cycle. a3 and wd3 hold their previous values.
- Scoreboard:
  - sb_set with sb_set_addr != 0 sets that bit on the edge.
  - sb_set_addr == 0 is ignored; bit 0 always reads 0.
- Simultaneous set and clear of the same register on one edge: set wins, because a new producer has been issued.
- hazard = busy[rs1] | busy[rs2], with x0 never busy. It reflects the scoreboard state before the current edge; no same-cycle bypass of a clear.

## Timing
- Reset values: RegWrite=0, a3=0, wd3=0, last_grant=1 (requester 0 wins the first contention), all scoreboard bits 0, hazard=0.
- reqN_ready is 0 while reset is high.
- Latency: handshake in cycle T gives RegWrite=1 in cycle T+1. The register file commits on the edge ending T+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate 0,1,0,1…
- Reset asserted mid-operation: in-flight output write is dropped (RegWrite forced 0 asynchronously) and all pending bits are lost. Requesters must re-present after reset.
- Scoreboard set in cycle T gives hazard visible in T+1 for a matching rs1/rs2.

## Structure
- Shared package `regfile_pkg`: XLEN, NREG, REG_ADDR_W=5, REG_ZERO=5'd0, requester index constants REQ_ALU=0 and REQ_LOAD=1.
- One sub-module: `rr_arbiter2`, a two-way round-robin arbiter.
  - Inputs: req[1:0], handshake.
  - Outputs: grant[1:0].
  - Holds last_grant internally.
- Top holds the output register, scoreboard vector and hazard logic.

## Test plan
- Reset then single request: req0 addr=5 data=0x1234 → req0_ready=1 same cycle; next cycle RegWrite=1, a3=5, wd3=0x1234.
- Contention: both valid for 4 cycles (req0 addr=3, req1 addr=7), each re-presenting after its handshake → grants 0,1,0,1; RegWrite high 4 consecutive cycles; loser's ready=0 while it waits.
- x0 write: req1 addr=0 data=0xFFFF → ready=1, RegWrite stays 0, last_grant moves to 1.
- Scoreboard: sb_set addr=9, then rs1=9 → hazard=1. The handshake writing addr 9 clears the bit on the edge where RegWrite rises; hazard=0 from that cycle on.
- Set/clear collision: sb_set addr=9 on the same edge as the addr-9 clear → bit stays 1, hazard remains 1 for rs2=9.
- Reset mid-stream: assert reset during a cycle where RegWrite=1 → RegWrite=0 immediately, all busy bits 0, first contention after release grants requester 0.
